bpu_update_arb: RTL and testbench
=================================

BPU_UPDATE_ARB -- requirements
Module: bpu_update_arb

Interface
REQ-001 SHALL have parameter NRET, default 4: commit slots per cycle.
REQ-002 SHALL have parameter PLEN, default 32: PC/target width.
REQ-003 SHALL have parameter DEPTH, default 8: queue entries; power of 2, DEPTH >= NRET.
REQ-004 SHALL have ports, in this order:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- commit_valid_i  in  NRET  per-slot branch-update valid.
- commit_pc_i  in  NRET x PLEN  branch PC.
- commit_is_cond_i  in  NRET  conditional branch.
- commit_taken_i  in  NRET  resolved direction.
- commit_target_i  in  NRET x PLEN  resolved target.
- commit_is_call_i  in  NRET  call.
- commit_is_ret_i  in  NRET  return.
- commit_ready_o  out  1  at least NRET free entries.
- update_ready_i  in  1  BPU accepts the head update.
- update_valid_o  out  1  head update valid.
- update_pc_o, update_target_o  out  PLEN each  head PC/target.
- update_is_cond_o, update_taken_o, update_is_call_o, update_is_ret_o  out  1 each  head flags.
- drop_cnt_o  out  16  saturating count of dropped updates.
- occupancy_o  out  $clog2(DEPTH)+1  current entry count.

Function
REQ-005 SHALL serialise up to NRET commit updates per cycle into one BPU update per cycle through a FIFO of DEPTH entries.
REQ-006 SHALL enqueue valid slots in ascending slot order, compacted and skipping invalid slots, in the cycle they are presented.
REQ-007 SHALL enqueue only as many slots as fit in free entries after this cycle's dequeue; lowest-index slots win.
REQ-008 SHALL drop the remaining valid slots and add their count to drop_cnt_o, saturating at 16'hFFFF.
REQ-009 SHALL drive commit_ready_o high iff (DEPTH - occupancy) >= NRET, from registered state only (no combinational path from commit_valid_i).
REQ-010 SHALL drive update_valid_o high iff occupancy != 0; update_*_o SHALL come from the head entry's flops.
REQ-011 SHALL dequeue one entry when update_valid_o && update_ready_i.
REQ-012 SHALL give a 1-cycle latency: an entry enqueued in cycle N into an empty queue appears on update_*_o in cycle N+1, never in cycle N (no bypass).
REQ-013 SHALL allow enqueue and dequeue in the same cycle; occupancy_next = occupancy + enq_count - deq; the dequeued slot counts as free for REQ-007.
REQ-014 SHALL use head/tail pointers wrapping modulo DEPTH; entry order SHALL be strict FIFO across wrap.
REQ-015 SHALL hold update_*_o stable while update_valid_o && !update_ready_i.
REQ-016 SHALL have no flush input: queued updates are architectural and SHALL NOT be discarded on pipeline flush.
REQ-017 SHALL not alter any field of a queued update.

Reset
REQ-018 SHALL, while rst_ni is low, asynchronously clear head, tail, occupancy and drop_cnt_o; commit_ready_o SHALL then be 1, update_valid_o 0, and all update_*_o data 0.
REQ-019 SHALL discard queue contents on reset mid-operation; the first post-reset cycle SHALL show an empty queue.
REQ-020 SHALL not require the entry data storage to be reset.

Verification
REQ-021 Single update: NRET=4, DEPTH=8, slot2 valid, pc=0x80000010, cond=1, taken=1, target=0x80000040 -> next cycle update_valid_o=1 with the same fields; one cycle later update_valid_o=0 (update_ready_i=1).
REQ-022 Order/compaction: slots 0,1,3 valid with pc 0x100, 0x104, 0x10C -> update_pc_o = 0x100, 0x104, 0x10C on three consecutive cycles.
REQ-023 Backpressure: update_ready_i=0, 4 updates per cycle -> commit_ready_o falls when occupancy reaches 5; a further 4-slot burst at occupancy 8 -> drop_cnt_o += 4, occupancy stays 8.
REQ-024 Simultaneous: occupancy 7, update_ready_i=1, 2 valid slots -> both enqueued, occupancy becomes 8, drop_cnt_o unchanged.
REQ-025 Wrap: 20 single updates with incrementing PC, update_ready_i toggling -> exact FIFO order, occupancy_o never exceeds 8.
REQ-026 Reset mid-operation: occupancy 5, rst_ni pulsed low -> same cycle update_valid_o=0, occupancy_o=0, drop_cnt_o=0, commit_ready_o=1.

Source files
------------

// File: rtl/bpu_update_arb.sv
// Branch-predictor update arbiter: compacts up to NRET commit-slot updates per
// cycle into a FIFO and presents one update per cycle from the head entry.
module bpu_update_arb #(
    parameter int NRET  = 4,
    parameter int PLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NRET-1:0]            commit_valid_i,
    input  logic [NRET-1:0][PLEN-1:0]  commit_pc_i,
    input  logic [NRET-1:0]            commit_is_cond_i,
    input  logic [NRET-1:0]            commit_taken_i,
    input  logic [NRET-1:0][PLEN-1:0]  commit_target_i,
    input  logic [NRET-1:0]            commit_is_call_i,
    input  logic [NRET-1:0]            commit_is_ret_i,
    output logic                       commit_ready_o,
    input  logic                       update_ready_i,
    output logic                       update_valid_o,
    output logic [PLEN-1:0]            update_pc_o,
    output logic [PLEN-1:0]            update_target_o,
    output logic                       update_is_cond_o,
    output logic                       update_taken_o,
    output logic                       update_is_call_o,
    output logic                       update_is_ret_o,
    output logic [15:0]                drop_cnt_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [PLEN-1:0] pc_mem  [DEPTH];
    logic [PLEN-1:0] tgt_mem [DEPTH];
    logic [3:0]      flg_mem [DEPTH];   // {cond, taken, call, ret}

    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   occ;
    logic [15:0]     drop_cnt;

    logic            deq;
    logic [CW-1:0]   free;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   enq_count;
    logic [CW-1:0]   drop_count;
    logic [NRET-1:0] wr_en;
    logic [AW-1:0]   wr_idx [NRET];

    assign update_valid_o = (occ != '0);
    assign deq            = update_valid_o && update_ready_i;
    assign commit_ready_o = ((CW'(DEPTH) - occ) >= CW'(NRET));
    assign occupancy_o    = occ;
    assign drop_cnt_o     = drop_cnt;

    // Head outputs are gated so an empty queue shows zero data without resetting storage.
    assign update_pc_o      = update_valid_o ? pc_mem[head]     : '0;
    assign update_target_o  = update_valid_o ? tgt_mem[head]    : '0;
    assign update_is_cond_o = update_valid_o && flg_mem[head][3];
    assign update_taken_o   = update_valid_o && flg_mem[head][2];
    assign update_is_call_o = update_valid_o && flg_mem[head][1];
    assign update_is_ret_o  = update_valid_o && flg_mem[head][0];

    // Compaction: each valid slot takes the next tail offset; slots past the free space drop.
    always_comb begin
        free   = CW'(DEPTH) - occ + CW'(deq);
        cnt    = '0;
        wr_en  = '0;
        for (int i = 0; i < NRET; i++) begin
            wr_idx[i] = tail + cnt[AW-1:0];
            wr_en[i]  = commit_valid_i[i] && (cnt < free);
            if (commit_valid_i[i]) cnt = cnt + CW'(1);
        end
        enq_count  = (cnt < free) ? cnt : free;
        drop_count = cnt - enq_count;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NRET; i++) begin
            if (wr_en[i]) begin
                pc_mem[wr_idx[i]]  <= commit_pc_i[i];
                tgt_mem[wr_idx[i]] <= commit_target_i[i];
                flg_mem[wr_idx[i]] <= {commit_is_cond_i[i], commit_taken_i[i],
                                       commit_is_call_i[i], commit_is_ret_i[i]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            drop_cnt <= '0;
        end else begin
            if (deq) head <= head + AW'(1);
            tail     <= tail + enq_count[AW-1:0];
            occ      <= occ + enq_count - CW'(deq);
            drop_cnt <= sat_add16(drop_cnt, drop_count);
        end
    end

endmodule

// File: tb/tb_bpu_update_arb.sv
// Directed bench for bpu_update_arb (NRET=4, PLEN=32, DEPTH=8) with
// immediate-assertion checks and a small FIFO model for the wrap sequence.
module tb_bpu_update_arb;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       cvalid, ccond, ctaken, ccall, cret;
    logic [3:0][31:0] cpc, ctgt;
    logic             cready, uready, uvalid;
    logic [31:0]      upc, utgt;
    logic             ucond, utaken, ucall, uret;
    logic [15:0]      drop_cnt;
    logic [3:0]       occ;

    int checks = 0;
    int errors = 0;

    bpu_update_arb #(.NRET(4), .PLEN(32), .DEPTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .commit_valid_i(cvalid), .commit_pc_i(cpc), .commit_is_cond_i(ccond),
        .commit_taken_i(ctaken), .commit_target_i(ctgt), .commit_is_call_i(ccall),
        .commit_is_ret_i(cret), .commit_ready_o(cready), .update_ready_i(uready),
        .update_valid_o(uvalid), .update_pc_o(upc), .update_target_o(utgt),
        .update_is_cond_o(ucond), .update_taken_o(utaken), .update_is_call_o(ucall),
        .update_is_ret_o(uret), .drop_cnt_o(drop_cnt), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cvalid = '0; ccond = '0; ctaken = '0; ccall = '0; cret = '0;
        cpc = '0; ctgt = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [3:0] v, input logic [31:0] base);
        cvalid = v;
        for (int i = 0; i < 4; i++) cpc[i] = base + 32'(4 * i);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] drain_exp [8];
    int          exp_drop;
    int          exp_size;
    logic        mdeq;

    initial begin
        clr();
        uready = 1'b0;
        #12;
        chk("rst_valid", uvalid, 0);
        chk("rst_occ", occ, 0);
        chk("rst_ready", cready, 1);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_pc", upc, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single update, no bypass
        uready = 1'b1;
        cvalid = 4'b0100; cpc[2] = 32'h8000_0010; ctgt[2] = 32'h8000_0040;
        ccond[2] = 1'b1; ctaken[2] = 1'b1;
        #1;
        chk("single_nobypass", uvalid, 0);
        tick();
        clr();
        chk("single_valid", uvalid, 1);
        chk("single_pc", upc, 32'h8000_0010);
        chk("single_tgt", utgt, 32'h8000_0040);
        chk("single_flags", {ucond, utaken, ucall, uret}, 4'b1100);
        chk("single_occ", occ, 1);
        tick();
        chk("single_gone", uvalid, 0);

        // Compaction of slots 0,1,3
        burst(4'b1011, 32'h100); cpc[2] = 32'hDEAD; cpc[3] = 32'h10C;
        tick();
        clr();
        chk("cmp_pc0", upc, 32'h100);
        chk("cmp_occ", occ, 3);
        tick();
        chk("cmp_pc1", upc, 32'h104);
        tick();
        chk("cmp_pc2", upc, 32'h10C);
        tick();
        chk("cmp_empty", uvalid, 0);

        // Backpressure and drops
        uready = 1'b0;
        burst(4'b1111, 32'h200);
        tick();
        chk("bp_occ4", occ, 4);
        chk("bp_ready4", cready, 1);
        clr(); cvalid = 4'b0001; cpc[0] = 32'h210;
        tick();
        chk("bp_occ5", occ, 5);
        chk("bp_ready5", cready, 0);
        burst(4'b1111, 32'h214);
        tick();
        chk("bp_occ8", occ, 8);
        chk("bp_drop1", drop_cnt, 1);
        burst(4'b1111, 32'h300);
        tick();
        clr();
        chk("bp_full_occ", occ, 8);
        chk("bp_drop5", drop_cnt, 5);
        chk("bp_hold_pc", upc, 32'h200);

        // Simultaneous enqueue/dequeue at occupancy 7
        uready = 1'b1;
        tick();
        chk("sim_occ7", occ, 7);
        cvalid = 4'b0110; cpc[1] = 32'h300; cpc[2] = 32'h304;
        tick();
        clr();
        chk("sim_occ8", occ, 8);
        chk("sim_drop", drop_cnt, 5);
        drain_exp = '{32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C, 32'h300, 32'h304};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_pc%0d", i), upc, drain_exp[i]);
            tick();
        end
        chk("drain_empty", uvalid, 0);

        // Wrap: 20 singles, ready toggling, modelled FIFO
        exp_q.delete();
        exp_drop = 5;
        for (int i = 0; i < 20; i++) begin
            uready = i[0];
            clr();
            cvalid[i % 4] = 1'b1;
            cpc[i % 4] = 32'h1000 + 32'(4 * i);
            #1;
            chk($sformatf("wrap_occ%0d", i), occ, exp_q.size());
            if (exp_q.size() != 0) chk($sformatf("wrap_pc%0d", i), upc, exp_q[0]);
            mdeq = (exp_q.size() != 0) && uready;
            exp_size = exp_q.size() - int'(mdeq);
            tick();
            if (mdeq) void'(exp_q.pop_front());
            if (exp_size < 8) exp_q.push_back(32'h1000 + 32'(4 * i));
            else exp_drop++;
        end
        clr();
        uready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
            chk("wrap_drain_pc", upc, exp_q.pop_front());
            tick();
        end
        chk("wrap_empty", uvalid, 0);
        chk("wrap_drop", drop_cnt, exp_drop);

        // Reset mid-operation
        uready = 1'b0;
        burst(4'b1111, 32'h500);
        tick();
        clr(); cvalid = 4'b0001; cpc[0] = 32'h510;
        tick();
        clr();
        chk("mid_occ5", occ, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", uvalid, 0);
        chk("mid_occ", occ, 0);
        chk("mid_drop", drop_cnt, 0);
        chk("mid_ready", cready, 1);
        chk("mid_pc", upc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_occ", occ, 0);
        chk("post_rst_valid", uvalid, 0);

        // Drop counter saturation
        burst(4'b1111, 32'h600);
        tick();
        tick();
        chk("sat_full", occ, 8);
        for (int i = 0; i < 16400; i++) tick();
        chk("sat_drop", drop_cnt, 16'hFFFF);
        clr();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
